alu_issue: RTL and testbench



---
 rtl/alu_pkg.sv | 74 +++++++
 rtl/alu.sv | 71 +++++++
 rtl/alu_issue.sv | 159 +++++++++++++++
 tb/tb_alu_issue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue/writeback wrapper:
// aluc codes, MIPS opcode/funct encodings, flag bit positions and
// the per-operation flag mask.
package alu_pkg;

    // ALU operation codes
    localparam logic [3:0] ALUC_ADDU = 4'b0000;
    localparam logic [3:0] ALUC_SUBU = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0011;
    localparam logic [3:0] ALUC_AND  = 4'b0100;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_NOR  = 4'b0111;
    localparam logic [3:0] ALUC_LUI  = 4'b1000;
    localparam logic [3:0] ALUC_SLTU = 4'b1010;
    localparam logic [3:0] ALUC_SLT  = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1100;
    localparam logic [3:0] ALUC_SRL  = 4'b1101;
    localparam logic [3:0] ALUC_SLL  = 4'b1110;

    // MIPS primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Bit positions inside the 4-bit {zero, carry, negative, overflow} vector
    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_OVF   = 0;

    // Output register occupancy
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} out_state_e;

    // Which flag bits carry meaning for a given operation; the rest read as 0
    function automatic logic [3:0] flag_mask(input logic [3:0] aluc);
        logic [3:0] m;
        m = 4'b0000;
        m[FLAG_ZERO] = 1'b1;
        m[FLAG_NEG]  = 1'b1;
        case (aluc)
            ALUC_ADDU, ALUC_SUBU, ALUC_SRA, ALUC_SRL, ALUC_SLL: m[FLAG_CARRY] = 1'b1;
            ALUC_ADD, ALUC_SUB:                                 m[FLAG_OVF]   = 1'b1;
            default:                                            m[FLAG_CARRY] = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU. Shifts take the amount from a[4:0] and shift b.
// carry is the unsigned carry-out for addu, the borrow for subu, and the
// last bit shifted out for shifts (0 for a shift by zero).
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluc,
    output logic [31:0] r,
    output logic        zero,
    output logic        carry,
    output logic        negative,
    output logic        overflow
);

    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic [32:0] shl_s;
    logic [32:0] shr_s;
    logic [32:0] sar_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};
    assign shl_s  = {1'b0, b} << a[4:0];
    assign shr_s  = {b, 1'b0} >> a[4:0];
    assign sar_s  = $unsigned($signed({b, 1'b0}) >>> a[4:0]);

    // Operation select with carry/overflow generation
    always_comb begin
        r        = 32'd0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (aluc)
            ALUC_ADDU, ALUC_ADD: begin
                r        = sum_s[31:0];
                carry    = sum_s[32];
                overflow = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            ALUC_SUBU, ALUC_SUB: begin
                r        = diff_s[31:0];
                carry    = diff_s[32];
                overflow = (a[31] != b[31]) && (diff_s[31] != a[31]);
            end
            ALUC_AND:  r = a & b;
            ALUC_OR:   r = a | b;
            ALUC_XOR:  r = a ^ b;
            ALUC_NOR:  r = ~(a | b);
            ALUC_LUI, 4'b1001: r = {b[15:0], 16'd0};
            ALUC_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            ALUC_SLTU: r = {31'd0, (a < b)};
            ALUC_SRA: begin
                r     = sar_s[32:1];
                carry = sar_s[0];
            end
            ALUC_SRL: begin
                r     = shr_s[32:1];
                carry = shr_s[0];
            end
            ALUC_SLL, 4'b1111: begin
                r     = shl_s[31:0];
                carry = shl_s[32];
            end
            default: r = 32'd0;
        endcase
    end

    assign zero     = (r == 32'd0);
    assign negative = r[31];

endmodule

// File: rtl/alu_issue.sv
// Single-stage issue/writeback wrapper around alu: decodes a MIPS word,
// selects operands, and registers result/destination/flags behind a
// valid/ready handshake. Optional feature macro: ALU_TRAP_EN (overflow of
// add/addi/sub raises out_trap and suppresses the register write).
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_wen,
    output logic [4:0]  out_waddr,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_flags,
    output logic        out_illegal,
    output logic        out_trap
);

    logic [5:0]  op_s, funct_s;
    logic [4:0]  rt_f_s, rd_f_s, shamt_s;
    logic [31:0] simm_s, zimm_s;
    logic        unused_s;

    assign op_s     = in_instr[31:26];
    assign rt_f_s   = in_instr[20:16];
    assign rd_f_s   = in_instr[15:11];
    assign shamt_s  = in_instr[10:6];
    assign funct_s  = in_instr[5:0];
    assign simm_s   = {{16{in_instr[15]}}, in_instr[15:0]};
    assign zimm_s   = {16'd0, in_instr[15:0]};
    assign unused_s = ^in_instr[25:21];

    logic        legal_s;
    logic [3:0]  aluc_s;
    logic [4:0]  dest_s;
    logic [31:0] a_s, b_s;

    // Decode op/funct into aluc, destination and operand selection
    always_comb begin
        legal_s = 1'b1;
        aluc_s  = ALUC_ADDU;
        dest_s  = rt_f_s;
        a_s     = in_rs;
        b_s     = zimm_s;
        case (op_s)
            OP_RTYPE: begin
                dest_s = rd_f_s;
                b_s    = in_rt;
                case (funct_s)
                    FN_ADD:  aluc_s = ALUC_ADD;
                    FN_ADDU: aluc_s = ALUC_ADDU;
                    FN_SUB:  aluc_s = ALUC_SUB;
                    FN_SUBU: aluc_s = ALUC_SUBU;
                    FN_AND:  aluc_s = ALUC_AND;
                    FN_OR:   aluc_s = ALUC_OR;
                    FN_XOR:  aluc_s = ALUC_XOR;
                    FN_NOR:  aluc_s = ALUC_NOR;
                    FN_SLT:  aluc_s = ALUC_SLT;
                    FN_SLTU: aluc_s = ALUC_SLTU;
                    FN_SLL:  begin aluc_s = ALUC_SLL; a_s = {27'd0, shamt_s};    end
                    FN_SRL:  begin aluc_s = ALUC_SRL; a_s = {27'd0, shamt_s};    end
                    FN_SRA:  begin aluc_s = ALUC_SRA; a_s = {27'd0, shamt_s};    end
                    FN_SLLV: begin aluc_s = ALUC_SLL; a_s = {27'd0, in_rs[4:0]}; end
                    FN_SRLV: begin aluc_s = ALUC_SRL; a_s = {27'd0, in_rs[4:0]}; end
                    FN_SRAV: begin aluc_s = ALUC_SRA; a_s = {27'd0, in_rs[4:0]}; end
                    default: legal_s = 1'b0;
                endcase
            end
            OP_ADDI:  begin aluc_s = ALUC_ADD;  b_s = simm_s; end
            OP_ADDIU: begin aluc_s = ALUC_ADDU; b_s = simm_s; end
            OP_SLTI:  begin aluc_s = ALUC_SLT;  b_s = simm_s; end
            OP_SLTIU: begin aluc_s = ALUC_SLTU; b_s = simm_s; end
            OP_ANDI:  aluc_s = ALUC_AND;
            OP_ORI:   aluc_s = ALUC_OR;
            OP_XORI:  aluc_s = ALUC_XOR;
            OP_LUI:   aluc_s = ALUC_LUI;
            default:  legal_s = 1'b0;
        endcase
    end

    logic [31:0] alu_r_s;
    logic        alu_z_s, alu_c_s, alu_n_s, alu_v_s;

    alu u_alu (
        .a        (a_s),
        .b        (b_s),
        .aluc     (aluc_s),
        .r        (alu_r_s),
        .zero     (alu_z_s),
        .carry    (alu_c_s),
        .negative (alu_n_s),
        .overflow (alu_v_s)
    );

    logic [31:0] wdata_d;
    logic [3:0]  flags_d;
    logic [4:0]  waddr_d;
    logic        trap_d, wen_d;

    assign wdata_d = legal_s ? alu_r_s : 32'd0;
    assign flags_d = legal_s ? ({alu_z_s, alu_c_s, alu_n_s, alu_v_s} & flag_mask(aluc_s)) : 4'b0000;
    assign waddr_d = legal_s ? dest_s : 5'd0;
`ifdef ALU_TRAP_EN
    assign trap_d  = legal_s && alu_v_s && ((aluc_s == ALUC_ADD) || (aluc_s == ALUC_SUB));
`else
    assign trap_d  = 1'b0;
`endif
    assign wen_d   = legal_s && (dest_s != 5'd0) && !trap_d;

    out_state_e state_q;
    logic       xfer_s;

    assign in_ready  = (state_q == ST_EMPTY) || out_ready;
    assign xfer_s    = in_valid && in_ready;
    assign out_valid = (state_q == ST_FULL);

    // Output register FSM: load on transfer, drain on out_ready, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_wen     <= 1'b0;
            out_waddr   <= 5'd0;
            out_wdata   <= 32'd0;
            out_flags   <= 4'b0000;
            out_illegal <= 1'b0;
            out_trap    <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY, ST_FULL: begin
                    if (xfer_s) begin
                        state_q     <= ST_FULL;
                        out_wen     <= wen_d;
                        out_waddr   <= waddr_d;
                        out_wdata   <= wdata_d;
                        out_flags   <= flags_d;
                        out_illegal <= !legal_s;
                        out_trap    <= trap_d;
                    end else if (out_ready) begin
                        state_q <= ST_EMPTY;
                        out_wen <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    out_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue. Expected values are hand
// computed; the ALU_TRAP_EN build changes only the add-overflow expectation.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_rs = 32'd0;
    logic [31:0] in_rt = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_wen;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;
    logic [3:0]  out_flags;
    logic        out_illegal;
    logic        out_trap;

    int n_cmp = 0;
    int n_bad = 0;
    logic [44:0] got;
    logic [31:0] consumed[$];

`ifdef ALU_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [44:0] exp;   // {valid, wen, waddr, wdata, flags, illegal, trap}
    } vec_t;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wen(out_wen), .out_waddr(out_waddr), .out_wdata(out_wdata),
        .out_flags(out_flags), .out_illegal(out_illegal), .out_trap(out_trap)
    );

    always #5 clk = ~clk;

    // Record every entry the writeback side actually consumes
    always @(posedge clk) begin
        if (out_valid && out_ready) consumed.push_back(out_wdata);
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [44:0] pack(input logic [44:0] e);
        return e;
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        in_valid = 1'b1; in_instr = instr; in_rs = rs; in_rt = rt;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = {out_valid, out_wen, out_waddr, out_wdata, out_flags, out_illegal, out_trap};
        n_cmp++;
        if (got !== 45'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want %h", got, 45'd0);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_arith();
        vec_t v[8];
        v[0] = '{"addu", enc_r(5'd0,5'd0,5'd3,5'd0,6'b100001), 32'hFFFFFFFF, 32'h1, {1'b1,1'b1,5'd3,32'h0,4'b1100,1'b0,1'b0}};
        v[1] = '{"add_ovf", enc_r(5'd0,5'd0,5'd4,5'd0,6'b100000), 32'h7FFFFFFF, 32'h1, {1'b1,!TRAP,5'd4,32'h80000000,4'b0011,1'b0,TRAP}};
        v[2] = '{"subu_borrow", enc_r(5'd0,5'd0,5'd8,5'd0,6'b100011), 32'h5, 32'h7, {1'b1,1'b1,5'd8,32'hFFFFFFFE,4'b0110,1'b0,1'b0}};
        v[3] = '{"sub", enc_r(5'd0,5'd0,5'd14,5'd0,6'b100010), 32'd10, 32'd3, {1'b1,1'b1,5'd14,32'd7,4'b0000,1'b0,1'b0}};
        v[4] = '{"addi_sext", enc_i(6'b001000,5'd1,5'd13,16'hFFFF), 32'h10, 32'h0, {1'b1,1'b1,5'd13,32'hF,4'b0000,1'b0,1'b0}};
        v[5] = '{"slt", enc_r(5'd0,5'd0,5'd9,5'd0,6'b101010), 32'hFFFFFFFF, 32'h1, {1'b1,1'b1,5'd9,32'h1,4'b0000,1'b0,1'b0}};
        v[6] = '{"sltu", enc_r(5'd0,5'd0,5'd15,5'd0,6'b101011), 32'hFFFFFFFF, 32'h1, {1'b1,1'b1,5'd15,32'h0,4'b1000,1'b0,1'b0}};
        v[7] = '{"addiu_carry", enc_i(6'b001001,5'd1,5'd20,16'h0001), 32'hFFFFFFFF, 32'h0, {1'b1,1'b1,5'd20,32'h0,4'b1100,1'b0,1'b0}};
        for (int i = 0; i < 8; i++) begin
            issue(v[i].instr, v[i].rs, v[i].rt);
            got = {out_valid, out_wen, out_waddr, out_wdata, out_flags, out_illegal, out_trap};
            n_cmp++;
            if (got !== v[i].exp) begin
                n_bad++; $display("FAIL %s: got %h want %h", v[i].name, got, v[i].exp);
            end
        end
    endtask

    task automatic test_logic();
        vec_t v[7];
        v[0] = '{"ori_zext", enc_i(6'b001101,5'd2,5'd5,16'h8001), 32'h12340000, 32'h0, {1'b1,1'b1,5'd5,32'h12348001,4'b0000,1'b0,1'b0}};
        v[1] = '{"nor", enc_r(5'd0,5'd0,5'd11,5'd0,6'b100111), 32'h0, 32'h0, {1'b1,1'b1,5'd11,32'hFFFFFFFF,4'b0010,1'b0,1'b0}};
        v[2] = '{"lui", enc_i(6'b001111,5'd0,5'd12,16'hABCD), 32'h0, 32'h0, {1'b1,1'b1,5'd12,32'hABCD0000,4'b0010,1'b0,1'b0}};
        v[3] = '{"andi_zext", enc_i(6'b001100,5'd3,5'd16,16'h8000), 32'hFFFFFFFF, 32'h0, {1'b1,1'b1,5'd16,32'h00008000,4'b0000,1'b0,1'b0}};
        v[4] = '{"xori_zero", enc_i(6'b001110,5'd3,5'd17,16'hFFFF), 32'h0000FFFF, 32'h0, {1'b1,1'b1,5'd17,32'h0,4'b1000,1'b0,1'b0}};
        v[5] = '{"slti_neg_imm", enc_i(6'b001010,5'd0,5'd18,16'h8000), 32'h0, 32'h0, {1'b1,1'b1,5'd18,32'h0,4'b1000,1'b0,1'b0}};
        v[6] = '{"sltiu_sext", enc_i(6'b001011,5'd0,5'd19,16'h8000), 32'h0, 32'h0, {1'b1,1'b1,5'd19,32'h1,4'b0000,1'b0,1'b0}};
        for (int i = 0; i < 7; i++) begin
            issue(v[i].instr, v[i].rs, v[i].rt);
            got = {out_valid, out_wen, out_waddr, out_wdata, out_flags, out_illegal, out_trap};
            n_cmp++;
            if (got !== v[i].exp) begin
                n_bad++; $display("FAIL %s: got %h want %h", v[i].name, got, v[i].exp);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[7];
        v[0] = '{"sra4", enc_r(5'd0,5'd0,5'd6,5'd4,6'b000011), 32'h0, 32'h80000000, {1'b1,1'b1,5'd6,32'hF8000000,4'b0010,1'b0,1'b0}};
        v[1] = '{"sll0", enc_r(5'd0,5'd0,5'd7,5'd0,6'b000000), 32'h0, 32'hA5A5A5A5, {1'b1,1'b1,5'd7,32'hA5A5A5A5,4'b0010,1'b0,1'b0}};
        v[2] = '{"sll1_carry", enc_r(5'd0,5'd0,5'd21,5'd1,6'b000000), 32'h0, 32'h80000001, {1'b1,1'b1,5'd21,32'h2,4'b0100,1'b0,1'b0}};
        v[3] = '{"srlv", enc_r(5'd1,5'd0,5'd10,5'd0,6'b000110), 32'h24, 32'hF8, {1'b1,1'b1,5'd10,32'hF,4'b0100,1'b0,1'b0}};
        v[4] = '{"srl31", enc_r(5'd0,5'd0,5'd22,5'd31,6'b000010), 32'h0, 32'h80000000, {1'b1,1'b1,5'd22,32'h1,4'b0000,1'b0,1'b0}};
        v[5] = '{"sllv_mod32", enc_r(5'd1,5'd0,5'd23,5'd0,6'b000100), 32'h20, 32'h1, {1'b1,1'b1,5'd23,32'h1,4'b0000,1'b0,1'b0}};
        v[6] = '{"srav1", enc_r(5'd1,5'd0,5'd24,5'd0,6'b000111), 32'h1, 32'h80000000, {1'b1,1'b1,5'd24,32'hC0000000,4'b0010,1'b0,1'b0}};
        for (int i = 0; i < 7; i++) begin
            issue(v[i].instr, v[i].rs, v[i].rt);
            got = {out_valid, out_wen, out_waddr, out_wdata, out_flags, out_illegal, out_trap};
            n_cmp++;
            if (got !== v[i].exp) begin
                n_bad++; $display("FAIL %s: got %h want %h", v[i].name, got, v[i].exp);
            end
        end
    endtask

    task automatic test_decode_edges();
        vec_t v[3];
        v[0] = '{"illegal_op3f", 32'hFC221234, 32'h5, 32'h6, {1'b1,1'b0,5'd0,32'h0,4'b0000,1'b1,1'b0}};
        v[1] = '{"illegal_funct", enc_r(5'd1,5'd2,5'd3,5'd0,6'b001000), 32'h5, 32'h6, {1'b1,1'b0,5'd0,32'h0,4'b0000,1'b1,1'b0}};
        v[2] = '{"addu_rd0", enc_r(5'd1,5'd2,5'd0,5'd0,6'b100001), 32'h1, 32'h2, {1'b1,1'b0,5'd0,32'h3,4'b0000,1'b0,1'b0}};
        for (int i = 0; i < 3; i++) begin
            issue(v[i].instr, v[i].rs, v[i].rt);
            got = {out_valid, out_wen, out_waddr, out_wdata, out_flags, out_illegal, out_trap};
            n_cmp++;
            if (got !== v[i].exp) begin
                n_bad++; $display("FAIL %s: got %h want %h", v[i].name, got, v[i].exp);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL drain_empty: got valid %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        consumed.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc_r(5'd1,5'd1,5'd1,5'd0,6'b100001); in_rs = 32'd1; in_rt = 32'd1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_wdata !== 32'd2) begin
            n_bad++; $display("FAIL bp_first_load: got valid %b data %h want 1 00000002", out_valid, out_wdata);
        end
        in_instr = enc_r(5'd2,5'd2,5'd2,5'd0,6'b100001); in_rs = 32'd2; in_rt = 32'd2;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_wdata !== 32'd2 || out_waddr !== 5'd1) begin
                n_bad++; $display("FAIL bp_hold%0d: got ready %b valid %b data %h addr %0d want 0 1 00000002 1",
                                  k, in_ready, out_valid, out_wdata, out_waddr);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_wdata !== 32'd4 || out_waddr !== 5'd2) begin
            n_bad++; $display("FAIL b2b_second: got %h/%0d want 00000004/2", out_wdata, out_waddr);
        end
        in_instr = enc_r(5'd3,5'd3,5'd3,5'd0,6'b100001); in_rs = 32'd3; in_rt = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_wdata !== 32'd6 || out_waddr !== 5'd3 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_third: got %h/%0d valid %b want 00000006/3 1", out_wdata, out_waddr, out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (consumed.size() !== 3 || consumed[0] !== 32'd2 || consumed[1] !== 32'd4 || consumed[2] !== 32'd6) begin
            n_bad++; $display("FAIL b2b_sequence: got %0d entries want 3 (2,4,6)", consumed.size());
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc_r(5'd1,5'd1,5'd25,5'd0,6'b100001); in_rs = 32'd7; in_rt = 32'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_wdata !== 32'd15) begin
            n_bad++; $display("FAIL rst_mid_load: got valid %b data %h want 1 0000000f", out_valid, out_wdata);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {out_valid, out_wen, out_waddr, out_wdata, out_flags, out_illegal, out_trap};
        n_cmp++;
        if (got !== 45'd0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_async: got %h ready %b want 0 1", got, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_after: got valid %b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_decode_edges();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
